// File: rtl/rom_fetch_arbiter_pkg.sv
// Shared constants for the ROM fetch arbiter: requester IDs, response FSM codes, legality helper.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
package rom_fetch_arbiter_pkg;

    // Default ROM size in bytes; legal word addresses are 0 .. ROM_BYTES-4
    localparam int ROM_BYTES_DEF = 512;

    // Requester IDs, also the bit index of each port in the arbiter req/gnt vectors
    localparam logic ROM_REQ_IF  = 1'b0;
    localparam logic ROM_REQ_MEM = 1'b1;

    // Per-port response FSM: BUSY means a response is presented this cycle
    typedef enum logic {
        RESP_IDLE = 1'b0,
        RESP_BUSY = 1'b1
    } resp_state_t;

    // Word-aligned and inside the ROM; compared unsigned at full width so high addresses never wrap
    function automatic logic addr_legal(input logic [63:0] addr, input logic [63:0] max_addr);
        return (addr[1:0] == 2'b00) && (addr <= max_addr);
    endfunction

endpackage

// File: rtl/rom_fetch_arbiter_rr.sv
// Two-way round-robin arbiter; bit 0 = IF, bit 1 = MEM.
// Latency: grant is combinational from req; last_winner updates at the edge ending a granted cycle.
// Backpressure: none; a losing requester simply wins the next contested cycle.
module rr_arbiter2
    import rom_fetch_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_winner;
    logic winner;

    // Single requester wins outright; on contention the port that did not win last time goes
    always_comb begin
        winner = last_winner;
        gnt    = 2'b00;
        case (req)
            2'b01:   winner = ROM_REQ_IF;
            2'b10:   winner = ROM_REQ_MEM;
            2'b11:   winner = ~last_winner;
            default: winner = last_winner;
        endcase
        if (req != 2'b00) begin
            gnt[winner] = 1'b1;
        end
    end

    // Remember the most recent winner; MEM after reset so IF takes the first contested grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_winner <= ROM_REQ_MEM;
        end else if (req != 2'b00) begin
            last_winner <= winner;
        end
    end

endmodule

// File: rtl/rom_fetch_arbiter.sv
// Shares the combinational-read instruction ROM between IF and MEM with round-robin grants.
// Latency: response one cycle after grant (two from request if it loses arbitration once).
// Backpressure: requests wait for gnt; responses have none and must be taken on rvalid.
module rom_fetch_arbiter
    import rom_fetch_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ROM_BYTES = ROM_BYTES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_err,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
);

    localparam logic [63:0] MAX_ADDR = 64'(ROM_BYTES - 4);

    logic [1:0]  arb_req;
    logic [1:0]  arb_gnt;
    logic        if_legal;
    logic        mem_legal;

    resp_state_t if_state, if_state_nxt;
    resp_state_t mem_state, mem_state_nxt;

    // IF keeps the in-flight word separate from the last delivered one so a flush can hide it
    logic [DATA_W-1:0] if_pend_data;
    logic              if_pend_err;
    logic [DATA_W-1:0] if_hold_data;
    logic              if_hold_err;
    logic              if_deliver;

    // Requests are masked during reset so no grant escapes while rst is low
    assign arb_req = {mem_req, if_req} & {2{rst}};

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (arb_req),
        .gnt (arb_gnt)
    );

    assign if_gnt    = arb_gnt[ROM_REQ_IF];
    assign mem_gnt   = arb_gnt[ROM_REQ_MEM];
    assign if_legal  = addr_legal(64'(if_addr), MAX_ADDR);
    assign mem_legal = addr_legal(64'(mem_addr), MAX_ADDR);

    // ROM is only driven for a legal granted address; otherwise it sees en=0, addr=0
    always_comb begin
        rom_en   = 1'b0;
        rom_addr = '0;
        if (if_gnt && if_legal) begin
            rom_en   = 1'b1;
            rom_addr = if_addr;
        end else if (mem_gnt && mem_legal) begin
            rom_en   = 1'b1;
            rom_addr = mem_addr;
        end
    end

    // Response FSMs: a grant this cycle means a response next cycle, back-to-back grants stay BUSY
    always_comb begin
        if_state_nxt  = RESP_IDLE;
        mem_state_nxt = RESP_IDLE;
        if (if_gnt) begin
            if_state_nxt = RESP_BUSY;
        end
        if (mem_gnt) begin
            mem_state_nxt = RESP_BUSY;
        end
    end

    // Response state registers; reset drops any response that was in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_state  <= RESP_IDLE;
            mem_state <= RESP_IDLE;
        end else begin
            if_state  <= if_state_nxt;
            mem_state <= mem_state_nxt;
        end
    end

    // A flush only kills the IF response presented in the current cycle
    assign if_deliver = (if_state == RESP_BUSY) && !if_flush;

    // IF data: capture on grant, commit to the held copy only when the word is actually delivered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_pend_data <= '0;
            if_pend_err  <= 1'b0;
            if_hold_data <= '0;
            if_hold_err  <= 1'b0;
        end else begin
            if (if_gnt) begin
                if_pend_data <= if_legal ? rom_inst : '0;
                if_pend_err  <= !if_legal;
            end
            if (if_deliver) begin
                if_hold_data <= if_pend_data;
                if_hold_err  <= if_pend_err;
            end
        end
    end

    assign if_rvalid = if_deliver;
    assign if_rdata  = if_deliver ? if_pend_data : if_hold_data;
    assign if_err    = if_deliver ? if_pend_err : if_hold_err;

    // MEM data register: loaded on grant and held until the next MEM response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rdata <= '0;
            mem_err   <= 1'b0;
        end else if (mem_gnt) begin
            mem_rdata <= mem_legal ? rom_inst : '0;
            mem_err   <= !mem_legal;
        end
    end

    assign mem_rvalid = (mem_state == RESP_BUSY);

    // Requesters must hold their address steady until the grant arrives
    if_addr_stable: assert property (@(posedge clk) disable iff (!rst)
        (if_req && !if_gnt) |=> $stable(if_addr));
    mem_addr_stable: assert property (@(posedge clk) disable iff (!rst)
        (mem_req && !mem_gnt) |=> $stable(mem_addr));

endmodule
